// File: rtl/serial_sub_using_fa_pkg.sv
// Shared helpers for the bit-serial subtractor: sizing of the bit counter.
package serial_sub_using_fa_pkg;

    // Width of a counter that must reach n-1 without wrapping (at least 1 bit).
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_sub_using_fa_fa_cell.sv
// Single-bit full adder: the only arithmetic in the serial subtractor.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = x ^ y ^ cin;
    assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/serial_sub_using_fa.sv
// Bit-serial N-bit subtractor: diff = a - b - bin, LSB first, one bit per clock,
// built as a + ~b + ~bin through one full-adder cell and a registered carry.
module serial_sub_using_fa
    import serial_sub_using_fa_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         bout
);

    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = S_IDLE,
        RUN  = S_RUN,
        DONE = S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic           w_accept;
    logic [N-1:0]   r_a_sh;
    logic [N-1:0]   r_b_sh;
    logic [N-1:0]   r_res;
    logic [CW-1:0]  r_cnt;
    logic           r_carry;
    logic [N-1:0]   r_diff;
    logic           r_bout;
    logic           w_y;
    logic           w_s;
    logic           w_cout;

    assign w_y = ~r_b_sh[0];

    fa_cell u_fa (
        .x    (r_a_sh[0]),
        .y    (w_y),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_cout)
    );

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next   = RUN;
                    w_accept = 1'b1;
                end
            end
            RUN: begin
                if (r_cnt == LAST_BIT) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    w_next   = RUN;
                    w_accept = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Carry starts at ~bin: a - b - bin == a + ~b + (1 - bin).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
        end else if (w_accept) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= ~bin;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_res   <= {w_s, r_res[N-1:1]};
            r_a_sh  <= {1'b0, r_a_sh[N-1:1]};
            r_b_sh  <= {1'b0, r_b_sh[N-1:1]};
            r_carry <= w_cout;
            r_cnt   <= r_cnt + 1'b1;
            if (r_cnt == LAST_BIT) begin
                r_diff <= {w_s, r_res[N-1:1]};
                r_bout <= ~w_cout;
            end
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign diff = r_diff;
    assign bout = r_bout;

endmodule

// File: tb/tb_serial_sub_using_fa.sv
// Bench for serial_sub_using_fa: N=4 and N=8 instances checked every cycle
// against an arithmetic reference, plus directed literal scenarios.
module tb_serial_sub_using_fa;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       bin4 = 1'b0;
    logic       busy4, done4, bout4;
    logic [3:0] diff4;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       bin8 = 1'b0;
    logic       busy8, done8, bout8;
    logic [7:0] diff8;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    serial_sub_using_fa #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
    );

    serial_sub_using_fa #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: {bout, diff} from plain signed arithmetic on the operands.
    function automatic logic [32:0] ref_sub(input int n, input longint a, input longint b,
                                            input bit bi);
        longint r;
        logic [32:0] o;
        r = a - b - longint'(bi);
        o = '0;
        o[31:0] = 32'(r & ((64'd1 << n) - 1));
        o[32] = (r < 0);
        return o;
    endfunction

    // Model: ph = 0 idle, 1..n running bit cycles, n+1 result cycle.
    int          ph[2] = '{0, 0};
    logic [32:0] pend[2];
    logic [31:0] ed[2] = '{0, 0};
    logic        eb[2] = '{0, 0};
    int          ops_done[2] = '{0, 0};

    task automatic model_step(input int i, input int n, input bit st, input longint av,
                              input longint bv, input bit bi);
        if (rst) begin
            ph[i] = 0;
            ed[i] = '0;
            eb[i] = 1'b0;
        end else if ((ph[i] == 0 || ph[i] == n + 1) && st) begin
            ph[i]   = 1;
            pend[i] = ref_sub(n, av, bv, bi);
        end else if (ph[i] >= 1 && ph[i] < n) begin
            ph[i]++;
        end else if (ph[i] == n) begin
            ph[i] = n + 1;
            ed[i] = pend[i][31:0];
            eb[i] = pend[i][32];
            ops_done[i]++;
        end else begin
            ph[i] = 0;
        end
    endtask

    always @(posedge clk) begin
        model_step(0, 4, start4, longint'(a4), longint'(b4), bin4);
        model_step(1, 8, start8, longint'(a8), longint'(b8), bin8);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy4", busy4, (ph[0] >= 1 && ph[0] <= 4));
            chk("done4", done4, (ph[0] == 5));
            chk("diff4", diff4, ed[0]);
            chk("bout4", bout4, eb[0]);
            chk("busy8", busy8, (ph[1] >= 1 && ph[1] <= 8));
            chk("done8", done8, (ph[1] == 9));
            chk("diff8", diff8, ed[1]);
            chk("bout8", bout8, eb[1]);
        end
    end

    // One start pulse on instance idx; checks latency, busy length and result literally.
    task automatic op(input int idx, input logic [31:0] av, input logic [31:0] bv,
                      input bit bi, input logic [31:0] exp_d, input bit exp_b);
        int cyc;
        int busyc;
        int lat;
        bit got;
        lat = (idx == 0) ? 5 : 9;
        cyc = 0;
        busyc = 0;
        got = 1'b0;
        if (idx == 0) begin
            start4 = 1'b1; a4 = av[3:0]; b4 = bv[3:0]; bin4 = bi;
        end else begin
            start8 = 1'b1; a8 = av[7:0]; b8 = bv[7:0]; bin8 = bi;
        end
        while (cyc < 30 && !got) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start4 = 1'b0;
                start8 = 1'b0;
            end
            if ((idx == 0) ? busy4 : busy8) busyc++;
            if ((idx == 0) ? done4 : done8) got = 1'b1;
        end
        chk("op_latency", got ? cyc : -1, lat);
        chk("op_busy_cycles", busyc, lat - 1);
        chk("op_diff", (idx == 0) ? diff4 : diff8, exp_d);
        chk("op_bout", (idx == 0) ? bout4 : bout8, exp_b);
    endtask

    initial begin
        int dn;
        int bad;
        int cyc;

        // Reference model pinned to hand-computed values.
        chk("ref_9_3", ref_sub(4, 9, 3, 1'b0), {1'b0, 32'h6});
        chk("ref_0_0_1", ref_sub(4, 0, 0, 1'b1), {1'b1, 32'hF});
        chk("ref_80_01", ref_sub(8, 'h80, 1, 1'b0), {1'b0, 32'h7F});

        repeat (2) @(negedge clk);
        chk("rst_busy", busy4, 0);
        chk("rst_done", done4, 0);
        chk("rst_diff", diff4, 0);
        chk("rst_bout", bout4, 0);
        rst = 1'b0;
        chk_en = 1'b1;

        op(0, 9, 3, 0, 'h6, 0);
        op(0, 3, 9, 0, 'hA, 1);
        op(0, 0, 0, 1, 'hF, 1);
        op(0, 'hF, 'hF, 0, 'h0, 0);
        repeat (2) @(negedge clk);

        // A start arriving mid-run is ignored.
        start4 = 1'b1; a4 = 4'd5; b4 = 4'd1; bin4 = 1'b0;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        start4 = 1'b1; a4 = 4'd1; b4 = 4'd5;
        @(negedge clk);
        start4 = 1'b0;
        dn = (done4 ? 1 : 0);
        repeat (10) begin
            @(negedge clk);
            if (done4) dn++;
        end
        chk("ignored_start_dones", dn, 1);
        chk("ignored_start_diff", diff4, 4);
        chk("ignored_start_bout", bout4, 0);

        // start held high: a result every 5 cycles, busy low only on done.
        start4 = 1'b1; a4 = 4'd7; b4 = 4'd2;
        dn = 0;
        bad = 0;
        repeat (15) begin
            @(negedge clk);
            if (done4) dn++;
            if (!busy4 && !done4) bad++;
        end
        start4 = 1'b0;
        chk("held_start_dones", dn, 3);
        chk("held_start_gaps", bad, 0);
        chk("held_start_diff", diff4, 5);
        repeat (6) @(negedge clk);

        // Reset during RUN discards the operation.
        start4 = 1'b1; a4 = 4'd8; b4 = 4'd1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", busy4, 0);
        chk("midrst_done", done4, 0);
        chk("midrst_diff", diff4, 0);
        chk("midrst_bout", bout4, 0);
        dn = 0;
        repeat (8) begin
            @(negedge clk);
            if (done4) dn++;
        end
        chk("midrst_no_done", dn, 0);
        op(0, 8, 1, 0, 'h7, 0);

        op(1, 'h80, 'h01, 0, 'h7F, 0);
        op(1, 'h00, 'hFF, 1, 'h00, 1);
        repeat (2) @(negedge clk);

        // Randomized traffic on both instances, operands changing every cycle.
        cyc = 0;
        while (ops_done[1] < 1030 && cyc < 40000) begin
            start4 = 1'($urandom_range(0, 1));
            a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
            start8 = ($urandom_range(0, 3) != 0);
            a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
            rst = ($urandom_range(0, 399) == 0);
            @(negedge clk);
            cyc++;
        end
        start4 = 1'b0;
        start8 = 1'b0;
        rst = 1'b0;
        chk("random_ops_completed", (ops_done[1] >= 1030), 1);
        repeat (12) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
